// File: rtl/alu_iter_pkg.sv
// rtl/alu_iter_pkg.sv - shared opcode and FSM state types for alu_iter
//
// Holds the 4-bit opcode enumeration and the three-state controller
// encoding used by alu_iter. Opcodes 11..15 have no name: they are illegal.
package alu_iter_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_iter_mul.sv
// rtl/alu_iter_mul.sv - shift-add multiplier iterator, one bit of b per cycle
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_start             load operands and begin iterating (ignored mid-run by
//                       construction: the controller only starts when idle)
//   i_a, i_b            multiplicand / multiplier, captured on i_start
//   o_done              high during the last of WIDTH iteration cycles
//   o_product           low WIDTH bits of a*b, valid while o_done is high
module alu_iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum;

  // Partial sum including the current multiplier bit; on the final cycle this
  // is the finished product, so the controller can register it directly.
  always_comb begin
    sum = acc_q + (b_q[0] ? a_q : '0);
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    if (i_start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      a_d    = i_a;
      b_d    = i_b;
      acc_d  = '0;
    end else if (busy_q) begin
      acc_d = sum;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      // Counter wraps back to zero on the last step, leaving it cleared.
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
    end
  end

  assign o_done    = busy_q && (cnt_q == LAST);
  assign o_product = sum;

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - handshaked ALU with single-cycle ops and iterative MUL
//
// Configuration macro: ALU_ITER_MUL_EN enables opcode 10 (MUL) through the
// alu_iter_mul iterator; without it opcode 10 is illegal and no BUSY path exists.
//
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_valid / o_ready    request handshake; i_op, i_a, i_b sampled on accept
//   o_valid / i_ready    result handshake; o_result, o_illegal held until taken
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal
);

  localparam int SHW = $clog2(WIDTH);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_iter: WIDTH must be a power of two in 8..64");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;
  logic             is_mul;

`ifdef ALU_ITER_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (mul_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_done    (mul_done),
    .o_product (mul_product)
  );
`endif

  // Single-cycle datapath; illegal opcodes yield a zero result.
  always_comb begin
    shamt       = i_b[SHW-1:0];
    alu_res     = '0;
    alu_illegal = 1'b0;
    is_mul      = 1'b0;
    case (op_e'(i_op))
      OP_ADD:  alu_res = i_a + i_b;
      OP_SUB:  alu_res = i_a - i_b;
      OP_AND:  alu_res = i_a & i_b;
      OP_OR:   alu_res = i_a | i_b;
      OP_XOR:  alu_res = i_a ^ i_b;
      OP_SLL:  alu_res = i_a << shamt;
      OP_SRL:  alu_res = i_a >> shamt;
      OP_SRA:  alu_res = $signed(i_a) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
`ifdef ALU_ITER_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`else
      OP_MUL:  alu_illegal = 1'b1;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
`ifdef ALU_ITER_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: o_ready = 1'b1;
      ST_BUSY: begin
`ifdef ALU_ITER_MUL_EN
        if (mul_done) begin
          state_d   = ST_DONE;
          result_d  = mul_product;
          illegal_d = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        o_valid = 1'b1;
        // Consuming the result frees the slot in the same cycle, so a new
        // request can be accepted with no bubble.
        o_ready = i_ready;
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    accept = i_valid && o_ready;
    if (accept) begin
      if (is_mul) begin
        state_d = ST_BUSY;
`ifdef ALU_ITER_MUL_EN
        mul_start = 1'b1;
`endif
      end else begin
        state_d   = ST_DONE;
        result_d  = alu_res;
        illegal_d = alu_illegal;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_result  = result_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - self-checking bench for alu_iter against an arithmetic model
module tb_alu_iter;

  localparam int W = 32;
`ifdef ALU_ITER_MUL_EN
  localparam bit MUL_ON  = 1'b1;
  localparam int MUL_LAT = W + 1;
`else
  localparam bit MUL_ON  = 1'b0;
  localparam int MUL_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [3:0]   i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic         o_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_op      (i_op),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_illegal (o_illegal)
  );

  // Reference: returns {illegal, result}.
  function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic [W-1:0]   ones;
    logic [2*W-1:0] p;
    logic           ill;
    int             s;
    s    = int'(b % W);
    ones = '1;
    r    = '0;
    ill  = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << s;
      4'd6:  r = a >> s;
      4'd7:  r = (a >> s) | (a[W-1] ? ~(ones >> s) : '0);
      4'd8:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin
        if (MUL_ON) begin
          p = {32'd0, a} * {32'd0, b};
          r = p[W-1:0];
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  // Issue one request with i_ready held high and wait for its result.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic [W-1:0] res, output logic ill);
    @(negedge clk);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(negedge clk);
    i_valid = 1'b0;
    i_op    = 4'($urandom);
    i_a     = $urandom;
    i_b     = $urandom;
    lat     = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = o_result;
    ill = o_illegal;
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_op    = '0;
    i_a     = '0;
    i_b     = '0;
    repeat (2) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b want=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got=%b want=1", o_ready); end
    checks++; if (o_result !== '0) begin errors++; $display("FAIL reset_o_result got=%h want=0", o_result); end
    checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL reset_o_illegal got=%b want=0", o_illegal); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle ready=%b valid=%b want ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_directed;
    logic [3:0]   ops[4]  = '{4'd0, 4'd7, 4'd8, 4'd9};
    logic [W-1:0] as[4]   = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] bs[4]   = '{32'h1, 32'h24, 32'h1, 32'h1};
    logic [W-1:0] exps[4] = '{32'h0, 32'hF800_0000, 32'h1, 32'h0};
    int lat; logic [W-1:0] res; logic ill;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], lat, res, ill);
      checks++; if (lat !== 1) begin errors++; $display("FAIL directed%0d_latency got=%0d want=1", i, lat); end
      checks++; if (res !== exps[i]) begin errors++; $display("FAIL directed%0d_result got=%h want=%h", i, res, exps[i]); end
      checks++; if (ill !== 1'b0) begin errors++; $display("FAIL directed%0d_illegal got=%b want=0", i, ill); end
    end
  endtask

  task automatic test_mul;
    int lat; int ready_bad;
    logic [W-1:0] exp_res;
    logic         exp_ill;
    exp_res = MUL_ON ? 32'h2345_6780 : 32'h0;
    exp_ill = !MUL_ON;
    @(negedge clk);
    i_valid = 1'b1; i_op = 4'd10; i_a = 32'h1234_5678; i_b = 32'h10;
    @(negedge clk);
    i_valid = 1'b0; i_op = 4'($urandom); i_a = $urandom; i_b = $urandom;
    lat = 1; ready_bad = 0;
    while (!o_valid && lat < 200) begin
      if (o_ready !== 1'b0) ready_bad++;
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_latency got=%0d want=%0d", lat, MUL_LAT); end
    checks++; if (o_result !== exp_res) begin errors++; $display("FAIL mul_result got=%h want=%h", o_result, exp_res); end
    checks++; if (o_illegal !== exp_ill) begin errors++; $display("FAIL mul_illegal got=%b want=%b", o_illegal, exp_ill); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL mul_busy_ready got=%0d cycles ready want=0", ready_bad); end
  endtask

  task automatic test_back_to_back;
    int stable_bad;
    @(negedge clk);
    i_ready = 1'b1; i_valid = 1'b1; i_op = 4'd0; i_a = 32'd3; i_b = 32'd4;
    @(negedge clk);
    checks++; if (o_valid !== 1'b1 || o_result !== 32'd7) begin
      errors++; $display("FAIL b2b_first valid=%b result=%h want valid=1 result=7", o_valid, o_result);
    end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got=%b want=1", o_ready); end
    i_op = 4'd4; i_a = 32'hF0; i_b = 32'hFF;
    @(negedge clk);
    checks++; if (o_valid !== 1'b1 || o_result !== 32'h0F) begin
      errors++; $display("FAIL b2b_second valid=%b result=%h want valid=1 result=0f", o_valid, o_result);
    end
    i_valid = 1'b0; i_ready = 1'b0; i_a = $urandom; i_b = $urandom;
    stable_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_valid !== 1'b1 || o_result !== 32'h0F || o_ready !== 1'b0 || o_illegal !== 1'b0) stable_bad++;
    end
    checks++; if (stable_bad !== 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles want=0", stable_bad); end
    i_ready = 1'b1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release valid=%b ready=%b want valid=0 ready=1", o_valid, o_ready);
    end
  endtask

  task automatic test_illegal;
    logic [3:0] ops[3] = '{4'd13, 4'd11, 4'd15};
    int lat; logic [W-1:0] res; logic ill;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], $urandom, $urandom, lat, res, ill);
      checks++; if (ill !== 1'b1 || res !== '0 || lat !== 1) begin
        errors++; $display("FAIL illegal_op%0d ill=%b res=%h lat=%0d want ill=1 res=0 lat=1", ops[i], ill, res, lat);
      end
    end
    do_op(4'd0, 32'd5, 32'd6, lat, res, ill);
    checks++; if (ill !== 1'b0 || res !== 32'd11) begin
      errors++; $display("FAIL illegal_clear ill=%b res=%h want ill=0 res=b", ill, res);
    end
  endtask

  task automatic test_random;
    int lat, exp_lat; logic [W-1:0] res, a, b; logic ill; logic [3:0] op; logic [W:0] exp;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
      b  = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      exp = model(op, a, b);
      exp_lat = (op == 4'd10) ? MUL_LAT : 1;
      do_op(op, a, b, lat, res, ill);
      checks++; if (res !== exp[W-1:0] || ill !== exp[W] || lat !== exp_lat) begin
        errors++;
        $display("FAIL random%0d op=%0d a=%h b=%h got res=%h ill=%b lat=%0d want res=%h ill=%b lat=%0d",
                 i, op, a, b, res, ill, lat, exp[W-1:0], exp[W], exp_lat);
      end
    end
  endtask

  task automatic test_reset_mid;
    int stale;
    @(negedge clk);
    i_ready = 1'b1;
    i_valid = 1'b1;
`ifdef ALU_ITER_MUL_EN
    i_op = 4'd10; i_a = 32'h1234_5678; i_b = 32'h10;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
`else
    i_op = 4'd0; i_a = 32'd1; i_b = 32'd2;
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL reset_mid_setup got valid=%b want=1", o_valid); end
`endif
    #2 rst = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid got=%b want=0", o_valid); end
    @(negedge clk);
    rst = 1'b0;
    i_ready = 1'b1;
    stale = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_valid !== 1'b0 || o_ready !== 1'b1) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL reset_mid_stale got=%0d bad cycles want=0", stale); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
